// File: rtl/dff_response_checker.sv
// Output-side checker for a single-bit flop path: predicts q from d delayed by LAT clocks
// and counts comparisons and mismatches over a run of programmable length.
module dff_response_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_checks,
    input  logic             d,
    input  logic             q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LAT-1:0]   r_hist;
    logic [CNT_W-1:0] r_num;
    logic [2:0]       r_fill;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_first_vld;
    logic [CNT_W-1:0] r_first_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_mis;
    logic [CNT_W-1:0] w_chk_inc;
    logic             w_last;
    logic             w_fill_end;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_mis      = (q != r_hist[LAT-1]);
    assign w_chk_inc  = r_chk_cnt + CNT_W'(1);
    assign w_last     = (w_chk_inc == r_num);
    assign w_fill_end = (r_fill == 3'(LAT - 1));

    // Expected-value history; shifts in every state so FILL only has to wait it out.
    generate
        if (LAT == 1) begin : g_hist1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_hist <= '0;
                else     r_hist <= d;
            end
        end else begin : g_histn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_hist <= '0;
                else     r_hist <= {r_hist[LAT-2:0], d};
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) w_next = (num_checks == '0) ? S_DONE : S_FILL;
            end
            S_FILL:  if (w_fill_end) w_next = S_RUN;
            S_RUN:   if (w_last)     w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num       <= '0;
            r_fill      <= '0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else if (w_accept) begin
            r_num       <= num_checks;
            r_fill      <= '0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
        end else begin
            if (r_state == S_FILL) r_fill <= r_fill + 3'd1;
            if (r_state == S_RUN) begin
                r_chk_cnt <= w_chk_inc;
                if (w_mis) begin
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    if (!r_first_vld) begin
                        r_first_vld <= 1'b1;
                        r_first_idx <= r_chk_cnt;
                    end
                end
            end
        end
    end

    // Status flags are registered from the state, so they trail it by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= (r_state == S_FILL) || (r_state == S_RUN);
            r_done <= (r_state == S_DONE);
            r_pass <= (r_state == S_DONE) && (r_err_cnt == '0);
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign chk_cnt       = r_chk_cnt;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_vld;
    assign first_err_idx = r_first_idx;

endmodule
